ctrl_cmd_parser: RTL

CTRL_CMD_PARSER -- requirements
Module: ctrl_cmd_parser

---
 rtl/ctrl_cmd_parser.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_cmd_parser.sv
// ctrl_cmd_parser: framed UART command decoder.
// Frame layout: SYNC_BYTE, OP, ARG_HI, ARG_LO, CHK, where CHK = OP ^ ARG_HI ^ ARG_LO.
// A good frame updates cmd_op/cmd_arg, pulses cmd_valid and answers ACK (8'h06).
// A bad checksum answers NAK (8'h15) and bumps the saturating err_count.
// Optional feature: define CTRL_CMD_PARSER_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES idle clocks. That case also counts as an error and sends
// no response.
// Reset is synchronous and active-high.
module ctrl_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 27000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_arg,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [7:0]  err_count
);

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  // The inter-byte timeout has to leave at least one idle cycle to count.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ctrl_cmd_parser: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OP,
    S_GET_AH,
    S_GET_AL,
    S_GET_CHK,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Shadow copies of the frame fields. They are only published when the checksum matches.
  logic [7:0]  r_op_sh;
  logic [7:0]  r_ah_sh;
  logic [7:0]  r_al_sh;

  logic [7:0]  r_cmd_op;
  logic [15:0] r_cmd_arg;
  logic        r_cmd_valid;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_err_count;

  logic        w_chk_strobe;
  logic        w_chk_ok;
  logic        w_timeout;
  logic        w_err_inc;

  // The checksum byte is being presented this cycle.
  assign w_chk_strobe = (r_state == S_GET_CHK) && rx_valid;
  assign w_chk_ok     = (rx_data == (r_op_sh ^ r_ah_sh ^ r_al_sh));

`ifdef CTRL_CMD_PARSER_TIMEOUT_EN
  // The counter only has to reach TIMEOUT_CYCLES-1. The expiry check fires on that value.
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] r_timer;
  logic               w_in_frame;

  assign w_in_frame = (r_state == S_GET_OP) || (r_state == S_GET_AH) ||
                      (r_state == S_GET_AL) || (r_state == S_GET_CHK);

  // If a byte arrives in the same cycle the timer expires, the byte wins.
  assign w_timeout = w_in_frame && !rx_valid && (r_timer == TIMER_LAST);

  // Count the idle cycles since the last accepted byte of the current frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_in_frame && !rx_valid && !w_timeout) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end
`else
  // Without the timeout option the parser waits as long as needed for the next byte.
  assign w_timeout = 1'b0;
`endif

  assign w_err_inc = (w_chk_strobe && !w_chk_ok) || w_timeout;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. The frame advances one step per accepted byte.
  // NOTE: the default assignment up front keeps this combinational block latch-free.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          w_next_state = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (rx_valid) begin
          w_next_state = S_GET_AH;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_GET_AH: begin
        if (rx_valid) begin
          w_next_state = S_GET_AL;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_GET_AL: begin
        if (rx_valid) begin
          w_next_state = S_GET_CHK;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_GET_CHK: begin
        if (rx_valid) begin
          w_next_state = S_RESP;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      S_RESP: begin
        // Bytes received here are dropped. The FSM only waits for the transmitter.
        if (!tx_busy) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic.
  // The strobes are forced low while reset is high, so a frame that is aborted
  // by reset never leaks a pulse.
  // tx_valid is raised in the first RESP cycle in which the transmitter is free.
  always_comb begin
    tx_valid  = (r_state == S_RESP) && !tx_busy && !reset;
    cmd_valid = r_cmd_valid && !reset;
  end

  // Capture the frame fields into the shadow registers as the bytes arrive.
  // NOTE: the shadows have no reset because each one is written before the checksum reads it.
  always_ff @(posedge clk) begin
    if (rx_valid && !reset) begin
      case (r_state)
        S_GET_OP: r_op_sh <= rx_data;
        S_GET_AH: r_ah_sh <= rx_data;
        S_GET_AL: r_al_sh <= rx_data;
        default: ;
      endcase
    end
  end

  // Check the frame.
  // On a match: publish the command, pulse cmd_valid one cycle later, and load ACK.
  // On a mismatch: load NAK and count the error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_op    <= 8'h00;
      r_cmd_arg   <= 16'h0000;
      r_cmd_valid <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_chk_strobe) begin
        if (w_chk_ok) begin
          r_cmd_op    <= r_op_sh;
          r_cmd_arg   <= {r_ah_sh, r_al_sh};
          r_cmd_valid <= 1'b1;
          r_tx_data   <= ACK_BYTE;
        end else begin
          r_tx_data   <= NAK_BYTE;
        end
      end
    end
  end

  // Saturating error counter. It counts checksum failures and inter-byte timeouts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (w_err_inc && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign cmd_op    = r_cmd_op;
  assign cmd_arg   = r_cmd_arg;
  assign tx_data   = r_tx_data;
  assign err_count = r_err_count;

endmodule
